// File: rtl/constraint_check_pkg.sv
// constraint_check_pkg: shared FSM state type and sizing helpers for the constraint checker
package constraint_check_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/constraint_check_seq_group_scan.sv
// constraint_group_scan: lowest-zero priority encoder over one group (bits -> any_fail, pos)
module constraint_group_scan import constraint_check_pkg::*; #(
  parameter int GROUP = 8,
  parameter int PW = clog2_min1(GROUP)
) (
  input  logic [GROUP-1:0] bits,
  output logic             any_fail,
  output logic [PW-1:0]    pos
);
  always_comb begin
    pos = '0;
    for (int i = GROUP - 1; i >= 0; i--) pos = bits[i] ? pos : PW'(i);
    any_fail = ~&bits;
  end
endmodule

// File: rtl/constraint_check_seq.sv
// constraint_check_seq: scans candidate constraint bits GROUP per cycle, reports sat/first-fail index, keeps stats
module constraint_check_seq import constraint_check_pkg::*; #(
  parameter int NUM_CON = 32,
  parameter int GROUP = 8,
  parameter int CAND_W = 64,
  parameter int CNT_W = 32,
  parameter int IDX_W = clog2_min1(NUM_CON)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cand_valid,
  output logic               cand_ready,
  input  logic [CAND_W-1:0]  cand_data,
  input  logic [NUM_CON-1:0] con_bits,
  input  logic [NUM_CON-1:0] con_en,
  input  logic               early_exit,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_sat,
  output logic [IDX_W-1:0]   res_idx,
  output logic [CAND_W-1:0]  res_cand,
  input  logic               clear_stats,
  output logic [CNT_W-1:0]   n_checked,
  output logic [CNT_W-1:0]   n_sat,
  output logic               found,
  output logic [CAND_W-1:0]  found_cand
);
  localparam int NGRP = ceil_div(NUM_CON, GROUP);
  localparam int PAD_W = NGRP * GROUP;
  localparam int GW = clog2_min1(NGRP);
  localparam int PW = clog2_min1(GROUP);
  state_t state;
  logic [NUM_CON-1:0] eff;
  logic [PAD_W-1:0] pad;
  logic [GROUP-1:0] slice;
  logic [GW-1:0] grp;
  logic [PW-1:0] pos;
  logic ee, fail_seen, any_fail, last, fail_now, hs;
  // padding above NUM_CON reads as satisfied so a short last group never fails
  always_comb begin
    pad = '1;
    pad[NUM_CON-1:0] = eff;
  end
  assign slice = pad[int'(grp) * GROUP +: GROUP];
  assign last = grp == GW'(NGRP - 1);
  assign fail_now = fail_seen | any_fail;
  assign hs = res_valid & res_ready;
  constraint_group_scan #(.GROUP(GROUP), .PW(PW)) u_scan (
    .bits(slice),
    .any_fail(any_fail),
    .pos(pos)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand_ready <= 1'b1;
      res_valid <= 1'b0;
      res_sat <= 1'b0;
      res_idx <= '0;
      res_cand <= '0;
      eff <= '0;
      ee <= 1'b0;
      fail_seen <= 1'b0;
      grp <= '0;
    end else begin
      case (state)
        IDLE: if (cand_valid) begin
          res_cand <= cand_data;
          eff <= con_bits | ~con_en;
          ee <= early_exit;
          grp <= '0;
          fail_seen <= 1'b0;
          res_idx <= '0;
          cand_ready <= 1'b0;
          state <= SCAN;
        end
        SCAN: begin
          // only the lowest failing group records an index, so early exit cannot change it
          if (any_fail && !fail_seen) begin
            fail_seen <= 1'b1;
            res_idx <= IDX_W'(int'(grp) * GROUP + int'(pos));
          end
          if (last || (ee && fail_now)) begin
            res_valid <= 1'b1;
            res_sat <= ~fail_now;
            state <= DONE;
          end else grp <= grp + 1'b1;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          res_sat <= 1'b0;
          cand_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // clear has priority over a coincident handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear_stats) begin
      n_checked <= '0;
      n_sat <= '0;
      found <= 1'b0;
      found_cand <= '0;
    end else if (hs) begin
      n_checked <= &n_checked ? n_checked : n_checked + 1'b1;
      if (res_sat) n_sat <= &n_sat ? n_sat : n_sat + 1'b1;
      if (res_sat && !found) begin
        found <= 1'b1;
        found_cand <= res_cand;
      end
    end
  end
endmodule

// File: tb/tb_constraint_check_seq.sv
// tb_constraint_check_seq: directed scoreboard bench for constraint_check_seq (32x8 and 13x4 configurations)
module tb_constraint_check_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic cand_valid_a, cand_valid_b, res_ready, clear_stats, early_exit;
  logic [63:0] cand_data;
  logic [31:0] con_bits, con_en;
  logic a_cand_ready, a_res_valid, a_res_sat, a_found;
  logic [4:0] a_res_idx;
  logic [63:0] a_res_cand, a_found_cand;
  logic [31:0] a_n_checked, a_n_sat;
  logic b_cand_ready, b_res_valid, b_res_sat, b_found;
  logic [3:0] b_res_idx;
  logic [63:0] b_res_cand, b_found_cand;
  logic [31:0] b_n_checked, b_n_sat;
  constraint_check_seq #(.NUM_CON(32), .GROUP(8), .CAND_W(64), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .cand_valid(cand_valid_a), .cand_ready(a_cand_ready),
    .cand_data(cand_data), .con_bits(con_bits), .con_en(con_en), .early_exit(early_exit),
    .res_valid(a_res_valid), .res_ready(res_ready), .res_sat(a_res_sat), .res_idx(a_res_idx),
    .res_cand(a_res_cand), .clear_stats(clear_stats), .n_checked(a_n_checked), .n_sat(a_n_sat),
    .found(a_found), .found_cand(a_found_cand)
  );
  constraint_check_seq #(.NUM_CON(13), .GROUP(4), .CAND_W(64), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .cand_valid(cand_valid_b), .cand_ready(b_cand_ready),
    .cand_data(cand_data), .con_bits(con_bits[12:0]), .con_en(con_en[12:0]), .early_exit(early_exit),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_sat(b_res_sat), .res_idx(b_res_idx),
    .res_cand(b_res_cand), .clear_stats(clear_stats), .n_checked(b_n_checked), .n_sat(b_n_sat),
    .found(b_found), .found_cand(b_found_cand)
  );
  typedef struct {
    logic sat;
    int idx;
    logic [63:0] cand;
    int lat;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input bit sel, input logic [31:0] bits, input logic [31:0] en, input logic ee,
                     input logic [63:0] cd, input logic sat, input int idx, input int lat,
                     input int hold, input bit clr);
    exp_t e;
    int l;
    logic [31:0] pre;
    sb.push_back('{sat, idx, cd, lat});
    chk("cand_ready_idle", sel ? b_cand_ready : a_cand_ready, 1);
    con_bits = bits;
    con_en = en;
    early_exit = ee;
    cand_data = cd;
    if (sel) cand_valid_b = 1'b1;
    else cand_valid_a = 1'b1;
    @(posedge clk); #1;
    cand_valid_a = 1'b0;
    cand_valid_b = 1'b0;
    con_bits = '0;
    con_en = '1;
    early_exit = 1'b0;
    cand_data = '0;
    l = 1;
    while (!(sel ? b_res_valid : a_res_valid) && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    e = sb.pop_front();
    chk("latency", 64'(l), 64'(e.lat));
    pre = a_n_checked;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      chk("cand_ready_held", a_cand_ready, 0);
      chk("n_checked_held", a_n_checked, pre);
    end
    chk("res_valid", sel ? b_res_valid : a_res_valid, 1);
    chk("res_sat", sel ? b_res_sat : a_res_sat, e.sat);
    chk("res_idx", sel ? 64'(b_res_idx) : 64'(a_res_idx), 64'(e.idx));
    chk("res_cand", sel ? b_res_cand : a_res_cand, e.cand);
    res_ready = 1'b1;
    clear_stats = clr;
    @(posedge clk); #1;
    res_ready = 1'b0;
    clear_stats = 1'b0;
    chk("res_valid_drop", sel ? b_res_valid : a_res_valid, 0);
    chk("cand_ready_back", sel ? b_cand_ready : a_cand_ready, 1);
  endtask
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] B12 = 32'hFFFF_EFFF;
  localparam logic [31:0] B3_20 = 32'hFFEF_FFF7;
  initial begin
    cand_valid_a = 1'b0;
    cand_valid_b = 1'b0;
    res_ready = 1'b0;
    clear_stats = 1'b0;
    early_exit = 1'b0;
    cand_data = '0;
    con_bits = '0;
    con_en = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_cand_ready", a_cand_ready, 1);
    chk("rst_res_valid", a_res_valid, 0);
    chk("rst_res_sat", a_res_sat, 0);
    chk("rst_res_idx", 64'(a_res_idx), 0);
    chk("rst_res_cand", a_res_cand, 0);
    chk("rst_n_checked", a_n_checked, 0);
    chk("rst_n_sat", a_n_sat, 0);
    chk("rst_found", a_found, 0);
    chk("rst_found_cand", a_found_cand, 0);
    @(posedge clk); #1;
    run(0, ONES, ONES, 0, 64'hC0FF_EE00_0000_0001, 1, 0, 5, 0, 0);
    chk("n_checked_1", a_n_checked, 1);
    chk("n_sat_1", a_n_sat, 1);
    chk("found_1", a_found, 1);
    chk("found_cand_1", a_found_cand, 64'hC0FF_EE00_0000_0001);
    run(0, B12, ONES, 0, 64'h2, 0, 12, 5, 0, 0);
    run(0, B12, ONES, 1, 64'h3, 0, 12, 3, 0, 0);
    run(0, B12, B12, 0, 64'h4, 1, 0, 5, 0, 0);
    chk("n_sat_masked", a_n_sat, 2);
    chk("found_cand_kept", a_found_cand, 64'hC0FF_EE00_0000_0001);
    run(0, B3_20, ONES, 0, 64'h5, 0, 3, 5, 0, 0);
    run(0, B3_20, ONES, 1, 64'h6, 0, 3, 2, 0, 0);
    run(0, ONES, ONES, 0, 64'h7, 1, 0, 5, 10, 0);
    chk("n_checked_7", a_n_checked, 7);
    chk("n_sat_3", a_n_sat, 3);
    run(0, ONES, ONES, 0, 64'h8, 1, 0, 5, 0, 1);
    chk("clr_n_checked", a_n_checked, 0);
    chk("clr_n_sat", a_n_sat, 0);
    chk("clr_found", a_found, 0);
    chk("clr_found_cand", a_found_cand, 0);
    run(0, ONES, ONES, 0, 64'h9, 1, 0, 5, 0, 0);
    chk("found_after_clr", a_found_cand, 64'h9);
    con_bits = ONES;
    cand_data = 64'hA;
    cand_valid_a = 1'b1;
    @(posedge clk); #1;
    cand_valid_a = 1'b0;
    @(posedge clk); #1;
    chk("scan_not_ready", a_cand_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst_res_valid", a_res_valid, 0);
    chk("arst_cand_ready", a_cand_ready, 1);
    chk("arst_n_checked", a_n_checked, 0);
    chk("arst_found", a_found, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run(1, 32'h0000_0FFF, ONES, 0, 64'hB, 0, 12, 5, 0, 0);
    run(1, 32'h0000_1FFF, ONES, 0, 64'hC, 1, 0, 5, 0, 0);
    run(1, 32'h0000_0FFF, ONES, 1, 64'hD, 0, 12, 5, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
